// File: rtl/input_port_buffer_if.sv
// Flit-side and arbiter-side signals of one router input port buffer.
// Handshake: a flit transfers in on a rising edge where wr_en=1 and full=0; it leaves on an edge where grant=1 and req=1.
`timescale 1ns/1ps
interface input_port_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] flit_in;
  logic              wr_en;
  logic              full;
  logic              overflow;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic [DATA_W-1:0] flit_out;
  logic [CNT_W-1:0]  count;

  // master: upstream link plus arbiter; slave: the buffer itself
  modport master (
    output flit_in, wr_en, grant,
    input  full, overflow, req, flit_id, length, flit_out, count
  );
  modport slave (
    input  flit_in, wr_en, grant,
    output full, overflow, req, flit_id, length, flit_out, count
  );
endinterface

// File: rtl/input_port_buffer.sv
// Per-port input FIFO feeding the five-port arbiter; exposes head flit ID and current packet length.
// rst is asynchronous and active-low.
`timescale 1ns/1ps
module input_port_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input_port_buffer_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] ID_HEADER = 3'b001;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [11:0]       length_q;
  logic              overflow_q;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_flit;
  logic              head_is_hdr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign push  = bus.wr_en && !full;
  assign pop   = bus.grant && !empty;

  // Head is forced to zero when empty so stale storage never looks like a header.
  assign head_flit   = empty ? '0 : mem[rd_ptr];
  assign head_is_hdr = (head_flit[2:0] == ID_HEADER);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.flit_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      length_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      overflow_q <= bus.wr_en && full;
      if (head_is_hdr) length_q <= head_flit[14:3];
    end
  end

  // The arbiter samples length while the header is at the head, before length_q has caught it.
  assign bus.length   = head_is_hdr ? head_flit[14:3] : length_q;
  assign bus.flit_out = head_flit;
  assign bus.flit_id  = head_flit[2:0];
  assign bus.req      = !empty;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: reset, streaming, overflow, wrap-around and length hold.
`timescale 1ns/1ps
module tb_input_port_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] nf;

  input_port_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  input_port_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [DATA_W-1:0] f, input logic g);
    bus.wr_en   = we;
    bus.flit_in = f;
    bus.grant   = g;
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [7:0] k);
    return {8'hA0, 8'h00, k, 8'h02};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b0, '0, 1'b0);
    step();
    step();
    check("rst_req",      32'(bus.req),      32'd0);
    check("rst_full",     32'(bus.full),     32'd0);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_flit_id",  32'(bus.flit_id),  32'd0);
    check("rst_flit_out", bus.flit_out,      32'd0);
    check("rst_length",   32'(bus.length),   32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);

    // release, push, then reset mid-stream
    rst = 1'b1;
    drive(1'b1, 32'h0000_0051, 1'b0);
    step();
    drive(1'b1, 32'h0000_0002, 1'b0);
    step();
    check("pre_rst_count", 32'(bus.count), 32'd2);
    drive(1'b0, '0, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_req",      32'(bus.req),     32'd0);
    check("mid_rst_count",    32'(bus.count),   32'd0);
    check("mid_rst_flit_out", bus.flit_out,     32'd0);
    check("mid_rst_length",   32'(bus.length),  32'd0);
    step();
    rst = 1'b1;

    // basic push / pop of a length-10 header
    drive(1'b1, 32'h0000_0051, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    check("basic_req",      32'(bus.req),     32'd1);
    check("basic_flit_id",  32'(bus.flit_id), 32'd1);
    check("basic_length",   32'(bus.length),  32'd10);
    check("basic_flit_out", bus.flit_out,     32'h0000_0051);
    check("basic_count",    32'(bus.count),   32'd1);
    bus.grant = 1'b1;
    step();
    bus.grant = 1'b0;
    check("pop_req",     32'(bus.req),     32'd0);
    check("pop_flit_id", 32'(bus.flit_id), 32'd0);
    check("pop_length",  32'(bus.length),  32'd10);
    check("pop_flit_out", bus.flit_out,    32'd0);

    // packet streaming with grant held high
    drive(1'b1, 32'h0000_0019, 1'b1);
    step();
    check("stream_hdr_id",  32'(bus.flit_id), 32'd1);
    check("stream_hdr_len", 32'(bus.length),  32'd3);
    drive(1'b1, 32'hAB00_0002, 1'b1);
    step();
    check("stream_body_id",  32'(bus.flit_id), 32'd2);
    check("stream_body_len", 32'(bus.length),  32'd3);
    check("stream_count",    32'(bus.count),   32'd1);
    drive(1'b1, 32'hCD00_0004, 1'b1);
    step();
    check("stream_tail_id",  32'(bus.flit_id), 32'd4);
    check("stream_tail_len", 32'(bus.length),  32'd3);
    check("stream_tail_out", bus.flit_out,     32'hCD00_0004);
    drive(1'b0, '0, 1'b1);
    step();
    check("stream_end_req", 32'(bus.req),    32'd0);
    check("stream_end_len", 32'(bus.length), 32'd3);
    step();
    check("empty_grant_count", 32'(bus.count), 32'd0);
    bus.grant = 1'b0;

    // fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, mk(8'(i)), 1'b0);
      exp_q.push_back(mk(8'(i)));
      step();
    end
    check("fill_full",     32'(bus.full),     32'd1);
    check("fill_count",    32'(bus.count),    32'd8);
    check("fill_overflow", 32'(bus.overflow), 32'd0);
    drive(1'b1, 32'hBAD0_0002, 1'b0);
    step();
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count),    32'd8);
    check("ovf_head",  bus.flit_out,      exp_q[0]);
    drive(1'b0, '0, 1'b0);
    step();
    check("ovf_clear", 32'(bus.overflow), 32'd0);

    // simultaneous push and pop while full
    drive(1'b1, 32'hDEAD_0002, 1'b1);
    check("full_pp_head", bus.flit_out, exp_q[0]);
    void'(exp_q.pop_front());
    step();
    drive(1'b0, '0, 1'b0);
    check("full_pp_overflow", 32'(bus.overflow), 32'd1);
    check("full_pp_count",    32'(bus.count),    32'd7);
    check("full_pp_full",     32'(bus.full),     32'd0);

    // drain: dropped flits must never appear
    bus.grant = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      check("drain_order", bus.flit_out, exp_q.pop_front());
      step();
    end
    bus.grant = 1'b0;
    check("drain_req", 32'(bus.req), 32'd0);

    // wrap-around at steady occupancy 3
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mk(8'(8'h40 + k)), 1'b0);
      exp_q.push_back(mk(8'(8'h40 + k)));
      step();
    end
    for (int k = 3; k < 23; k++) begin
      nf = mk(8'(8'h40 + k));
      drive(1'b1, nf, 1'b1);
      check("wrap_order", bus.flit_out, exp_q.pop_front());
      exp_q.push_back(nf);
      step();
      check("wrap_count", 32'(bus.count), 32'd3);
    end
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("wrap_tail_order", bus.flit_out, exp_q.pop_front());
      step();
    end
    bus.grant = 1'b0;
    check("wrap_empty", 32'(bus.req), 32'd0);

    // length hold across a queued second header
    drive(1'b1, 32'h0000_0321, 1'b0);
    step();
    check("hold_len100_comb", 32'(bus.length), 32'd100);
    drive(1'b1, 32'h0000_0002, 1'b0);
    step();
    drive(1'b1, 32'h0000_0039, 1'b0);
    step();
    drive(1'b0, '0, 1'b1);
    step();
    check("hold_body_id",  32'(bus.flit_id), 32'd2);
    check("hold_len100",   32'(bus.length),  32'd100);
    step();
    check("hold_hdr2_id",  32'(bus.flit_id), 32'd1);
    check("hold_len7",     32'(bus.length),  32'd7);
    step();
    bus.grant = 1'b0;
    check("hold_empty_len", 32'(bus.length), 32'd7);

    // unknown ID is forwarded and leaves length alone
    drive(1'b1, 32'h0000_FFF7, 1'b0);
    step();
    drive(1'b0, '0, 1'b1);
    check("odd_id",       32'(bus.flit_id), 32'd7);
    check("odd_flit_out", bus.flit_out,     32'h0000_FFF7);
    check("odd_length",   32'(bus.length),  32'd7);
    step();
    bus.grant = 1'b0;
    check("odd_pop_len", 32'(bus.length), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
